disp_share_arbiter: RTL and testbench

// - Shares the 3-digit seven-segment display mux between two requesters (e.g. PWM duty readout, status message).
// - Time-sliced round-robin with a minimum hold time per owner.
// - Drives the digit inputs of the display mux: hex2..hex0, dp, en.
// - Blank frame when nobody owns the display.

---
 rtl/disp_share_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_disp_share_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/disp_share_arbiter.sv
// Time-sliced round-robin owner of the 3-digit seven-segment display mux.
// Optional blank gap between owners when DISP_ARB_GAP_EN is defined.
module disp_share_arbiter #(
  parameter int TICK_DIV   = 50000,
  parameter int HOLD_TICKS = 1000,
  parameter int GAP_TICKS  = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [20:0] data0,
  input  logic [20:0] data1,
  output logic [1:0]  grant,
  output logic [4:0]  hex2,
  output logic [4:0]  hex1,
  output logic [4:0]  hex0,
  output logic [2:0]  dp_out,
  output logic [2:0]  en_out,
  output logic        switch_p
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int MX = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int CW = $clog2(MX + 1);

  localparam logic [4:0]  BLANK_HEX = 5'b10010;
  localparam logic [20:0] BLANK = {3'b000, 3'b000, BLANK_HEX, BLANK_HEX, BLANK_HEX};

`ifdef DISP_ARB_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_t;
`endif

  state_t          r_state;
  logic [1:0]      r_grant;
  logic            r_sw;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_pre;
  logic [20:0]     r_out;
  logic            w_tick;

`ifdef DISP_ARB_GAP_EN
  logic            r_tgt;
  logic            w_req_t;
  logic            w_req_o;
  assign w_req_t = r_tgt ? req1 : req0;
  assign w_req_o = r_tgt ? req0 : req1;
`endif

  assign w_tick = (r_pre == PW'(TICK_DIV - 1));

  // Free-running prescaler producing the hold tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
    end
  end

  // Ownership FSM; the down-counter is the hold timer in OWNx
  // and the gap timer in GAP (the states are exclusive)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_grant <= 2'b00;
      r_sw    <= 1'b0;
      r_cnt   <= '0;
`ifdef DISP_ARB_GAP_EN
      r_tgt   <= 1'b0;
`endif
    end else begin
      r_sw <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req0) begin
            r_state <= S_OWN0;
            r_grant <= 2'b01;
            r_sw    <= 1'b1;
            r_cnt   <= CW'(HOLD_TICKS);
          end else if (req1) begin
            r_state <= S_OWN1;
            r_grant <= 2'b10;
            r_sw    <= 1'b1;
            r_cnt   <= CW'(HOLD_TICKS);
          end
        end
        S_OWN0: begin
          if (!req0 && !req1) begin
            r_state <= S_IDLE;
            r_grant <= 2'b00;
            r_sw    <= 1'b1;
          end else if (!req0 || (req1 && r_cnt == '0)) begin
`ifdef DISP_ARB_GAP_EN
            r_state <= S_GAP;
            r_grant <= 2'b00;
            r_tgt   <= 1'b1;
            r_cnt   <= CW'(GAP_TICKS);
`else
            r_state <= S_OWN1;
            r_grant <= 2'b10;
            r_cnt   <= CW'(HOLD_TICKS);
`endif
            r_sw    <= 1'b1;
          end else if (w_tick && r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_OWN1: begin
          if (!req1 && !req0) begin
            r_state <= S_IDLE;
            r_grant <= 2'b00;
            r_sw    <= 1'b1;
          end else if (!req1 || (req0 && r_cnt == '0)) begin
`ifdef DISP_ARB_GAP_EN
            r_state <= S_GAP;
            r_grant <= 2'b00;
            r_tgt   <= 1'b0;
            r_cnt   <= CW'(GAP_TICKS);
`else
            r_state <= S_OWN0;
            r_grant <= 2'b01;
            r_cnt   <= CW'(HOLD_TICKS);
`endif
            r_sw    <= 1'b1;
          end else if (w_tick && r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
`ifdef DISP_ARB_GAP_EN
        S_GAP: begin
          if (r_cnt == '0) begin
            if (w_req_t) begin
              r_state <= r_tgt ? S_OWN1 : S_OWN0;
              r_grant <= r_tgt ? 2'b10 : 2'b01;
              r_sw    <= 1'b1;
              r_cnt   <= CW'(HOLD_TICKS);
            end else if (w_req_o) begin
              r_state <= r_tgt ? S_OWN0 : S_OWN1;
              r_grant <= r_tgt ? 2'b01 : 2'b10;
              r_sw    <= 1'b1;
              r_cnt   <= CW'(HOLD_TICKS);
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_tick) begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  // Display registers follow the owner held before the edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out <= BLANK;
    end else begin
      case (r_state)
        S_OWN0:  r_out <= data0;
        S_OWN1:  r_out <= data1;
        default: r_out <= BLANK;
      endcase
    end
  end

  assign grant    = r_grant;
  assign switch_p = r_sw;
  assign en_out   = r_out[20:18];
  assign dp_out   = r_out[17:15];
  assign hex2     = r_out[14:10];
  assign hex1     = r_out[9:5];
  assign hex0     = r_out[4:0];

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Directed bench for disp_share_arbiter (TICK_DIV=4, HOLD_TICKS=3, GAP_TICKS=2).
// Covers both builds of DISP_ARB_GAP_EN.
module tb_disp_share_arbiter;

  logic        clk;
  logic        reset;
  logic        req0;
  logic        req1;
  logic [20:0] data0;
  logic [20:0] data1;
  logic [1:0]  grant;
  logic [4:0]  hex2;
  logic [4:0]  hex1;
  logic [4:0]  hex0;
  logic [2:0]  dp_out;
  logic [2:0]  en_out;
  logic        switch_p;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  disp_share_arbiter #(
    .TICK_DIV(4),
    .HOLD_TICKS(3),
    .GAP_TICKS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req0(req0),
    .req1(req1),
    .data0(data0),
    .data1(data1),
    .grant(grant),
    .hex2(hex2),
    .hex1(hex1),
    .hex0(hex0),
    .dp_out(dp_out),
    .en_out(en_out),
    .switch_p(switch_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input logic [1:0] exp, input int maxc,
                            output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (grant !== exp && cnt < maxc);
  endtask

  initial begin
    reset = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    data0 = 21'h1C_0123;
    data1 = 21'h07_1234;
    repeat (3) step();

    chk("rst_grant", grant, 2'b00);
    chk("rst_en", en_out, 3'b000);
    chk("rst_dp", dp_out, 3'b000);
    chk("rst_hex2", hex2, 5'h12);
    chk("rst_hex1", hex1, 5'h12);
    chk("rst_hex0", hex0, 5'h12);
    chk("rst_sw", switch_p, 1'b0);

    reset = 1'b1;
    req0  = 1'b1;
    step();
    chk("own0_grant", grant, 2'b01);
    chk("own0_sw", switch_p, 1'b1);
    chk("own0_lag_en", en_out, 3'b000);
    step();
    chk("own0_sw_off", switch_p, 1'b0);
    chk("own0_data", {en_out, dp_out, hex2, hex1, hex0}, 21'h1C_0123);

    data0 = 21'h15_4321;
    step();
    chk("own0_upd", {en_out, dp_out, hex2, hex1, hex0}, 21'h15_4321);

    req0 = 1'b0;
    step();
    chk("drop0_grant", grant, 2'b00);
    chk("drop0_sw", switch_p, 1'b1);
    step();
    chk("drop0_blank_en", en_out, 3'b000);
    chk("drop0_blank_hex2", hex2, 5'h12);

    req0 = 1'b1;
    req1 = 1'b1;
    step();
    chk("both_first", grant, 2'b01);
`ifdef DISP_ARB_GAP_EN
    wait_grant(2'b00, 40, n);
    chk("gap_enter", grant, 2'b00);
    chk("gap_enter_sw", switch_p, 1'b1);
    chk("gap_enter_len", (n >= 8 && n <= 16), 1'b1);
    step();
    chk("gap_blank_en", en_out, 3'b000);
    wait_grant(2'b10, 20, n);
    chk("gap_exit", grant, 2'b10);
    chk("gap_exit_sw", switch_p, 1'b1);
    chk("gap_len", (n + 1 >= 4 && n + 1 <= 12), 1'b1);
`else
    wait_grant(2'b10, 40, n);
    chk("rr_to1", grant, 2'b10);
    chk("rr_to1_sw", switch_p, 1'b1);
    chk("rr_to1_len", (n >= 8 && n <= 16), 1'b1);
`endif
    step();
    chk("own1_data", {en_out, dp_out, hex2, hex1, hex0}, 21'h07_1234);
    wait_grant(2'b01, 60, n);
    chk("rr_to0", grant, 2'b01);
    chk("rr_to0_sw", switch_p, 1'b1);
`ifdef DISP_ARB_GAP_EN
    chk("rr_to0_len", (n >= 10 && n <= 30), 1'b1);
`else
    chk("rr_to0_len", (n >= 7 && n <= 16), 1'b1);
`endif

    req0 = 1'b0;
    step();
`ifdef DISP_ARB_GAP_EN
    chk("hand_gap", grant, 2'b00);
    chk("hand_gap_sw", switch_p, 1'b1);
    wait_grant(2'b10, 20, n);
`endif
    chk("hand_to1", grant, 2'b10);
    chk("hand_to1_sw", switch_p, 1'b1);

    req1 = 1'b0;
    step();
    chk("drop1_grant", grant, 2'b00);
    chk("drop1_sw", switch_p, 1'b1);
    step();
    chk("drop1_blank_en", en_out, 3'b000);
    chk("drop1_blank_hex1", hex1, 5'h12);

    req1 = 1'b1;
    step();
    chk("own1_again", grant, 2'b10);
    step();
    step();
    chk("own1_out", {en_out, dp_out, hex2, hex1, hex0}, 21'h07_1234);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_grant", grant, 2'b00);
    chk("arst_en", en_out, 3'b000);
    chk("arst_hex0", hex0, 5'h12);
    chk("arst_sw", switch_p, 1'b0);
    #2;
    reset = 1'b1;
    step();
    chk("rel_grant", grant, 2'b10);
    chk("rel_sw", switch_p, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
